// File: rtl/set_assoc_cache.sv
// Two-way set-associative write-through, no-write-allocate cache with a line-fill/write-through FSM.
// Optional build macro CACHE_WRITE_UPDATE_EN: write hits update the cached word instead of invalidating the way.
module set_assoc_cache #(
   parameter int SET_BITS       = 6,
   parameter int WORDS_PER_LINE = 2,
   parameter int TAG_W          = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_r_en,
   input  logic                        mem_w_en,
   input  logic [31:0]                 addr,
   input  logic [31:0]                 wdata,
   output logic [31:0]                 rdata,
   output logic                        ready,
   output logic                        mem_req_r,
   output logic                        mem_req_w,
   output logic [31:0]                 mem_addr,
   output logic [31:0]                 mem_wdata,
   input  logic [32*WORDS_PER_LINE-1:0] mem_rdata,
   input  logic                        mem_ready
);
   // state   | meaning
   // S_IDLE  | accept requests; read hits complete combinationally
   // S_FILL  | line fill outstanding; waiting for mem_ready
   // S_WRITE | write-through outstanding; waiting for mem_ready

   localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
   localparam int WSEL_W    = (WORD_BITS > 0) ? WORD_BITS : 1;
   localparam int OFF       = 2 + WORD_BITS;
   localparam int SETS      = 1 << SET_BITS;
   localparam int LINE_W    = 32 * WORDS_PER_LINE;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

   state_t state_q, state_d;
   logic [31:0] addr_q, wdata_q;

   logic [SETS-1:0]   valid_q [0:1];
   logic [SETS-1:0]   lru_q;
   logic [TAG_W-1:0]  tag_mem  [0:1][0:SETS-1];
   logic [LINE_W-1:0] line_mem [0:1][0:SETS-1];

   // IDLE looks up the live CPU address; FILL/WRITE use the latched one
   logic [31:0]         lk_addr;
   logic [SET_BITS-1:0] lk_idx;
   logic [TAG_W-1:0]    lk_tag;
   logic [WSEL_W-1:0]   lk_word;
   logic                hit0, hit1, hit, hit_way, victim;
   logic [LINE_W-1:0]   hit_line;
   logic [31:0]         hit_word, fill_word;

   assign lk_addr  = (state_q == S_IDLE) ? addr : addr_q;
   assign lk_idx   = SET_BITS'(lk_addr >> OFF);
   assign lk_tag   = TAG_W'(lk_addr >> (OFF + SET_BITS));
   assign lk_word  = WSEL_W'((lk_addr >> 2) & 32'(WORDS_PER_LINE - 1));

   assign hit0     = valid_q[0][lk_idx] && (tag_mem[0][lk_idx] == lk_tag);
   assign hit1     = valid_q[1][lk_idx] && (tag_mem[1][lk_idx] == lk_tag);
   assign hit      = hit0 | hit1;
   assign hit_way  = hit1;
   assign victim   = lru_q[lk_idx];
   assign hit_line = hit1 ? line_mem[1][lk_idx] : line_mem[0][lk_idx];
   assign hit_word = hit_line[{lk_word, 5'b0} +: 32];
   assign fill_word = mem_rdata[{lk_word, 5'b0} +: 32];

   assign mem_req_r = (state_q == S_FILL);
   assign mem_req_w = (state_q == S_WRITE);
   assign mem_addr  = (state_q == S_FILL)  ? (addr_q & ~32'(4 * WORDS_PER_LINE - 1)) :
                      (state_q == S_WRITE) ? addr_q : 32'd0;
   assign mem_wdata = (state_q == S_WRITE) ? wdata_q : 32'd0;

   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      rdata   = 32'd0;
      case (state_q)
         S_IDLE: begin
            if (mem_w_en) begin
               state_d = S_WRITE;
            end else if (mem_r_en) begin
               if (hit) begin
                  ready = 1'b1;
                  rdata = hit_word;
               end else begin
                  state_d = S_FILL;
               end
            end else begin
               ready = 1'b1;
            end
         end
         S_FILL: begin
            if (mem_ready) begin
               ready   = 1'b1;
               rdata   = fill_word;
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (mem_ready) begin
               ready   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         lru_q      <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && (mem_w_en || mem_r_en)) begin
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (state_q == S_IDLE && !mem_w_en && mem_r_en && hit)
            lru_q[lk_idx] <= ~hit_way;
         if (state_q == S_FILL && mem_ready) begin
            valid_q[victim][lk_idx] <= 1'b1;
            lru_q[lk_idx]           <= ~victim;
         end
`ifndef CACHE_WRITE_UPDATE_EN
         if (state_q == S_WRITE && mem_ready && hit)
            valid_q[hit_way][lk_idx] <= 1'b0;
`endif
      end
   end

   // Tag/data arrays carry no reset; valid bits alone qualify them
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == S_FILL && mem_ready) begin
            tag_mem[victim][lk_idx]  <= lk_tag;
            line_mem[victim][lk_idx] <= mem_rdata;
         end
`ifdef CACHE_WRITE_UPDATE_EN
         if (state_q == S_WRITE && mem_ready && hit)
            line_mem[hit_way][lk_idx][{lk_word, 5'b0} +: 32] <= wdata_q;
`endif
      end
   end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: behavioural memory with configurable latency plus CPU read/write tasks.
module tb_set_assoc_cache;
   localparam int WPL = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 mem_r_en, mem_w_en;
   logic [31:0]          addr, wdata, rdata;
   logic                 ready, mem_req_r, mem_req_w;
   logic [31:0]          mem_addr, mem_wdata;
   logic [32*WPL-1:0]    mem_rdata;
   logic                 mem_ready;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q [$];
   logic [31:0] store [logic [29:0]];
   bit mem_auto = 1'b1;
   int mem_lat  = 3;
   int lat_cnt  = 0;
   int wr_count = 0;
`ifdef CACHE_WRITE_UPDATE_EN
   bit wr_upd = 1'b1;
`else
   bit wr_upd = 1'b0;
`endif

   set_assoc_cache #(.SET_BITS(6), .WORDS_PER_LINE(WPL), .TAG_W(10)) dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
      .mem_req_r(mem_req_r), .mem_req_w(mem_req_w), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] store_rd(input logic [31:0] a);
      if (store.exists(a[31:2])) return store[a[31:2]];
      return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
   endfunction

   // memory: mem_ready pulses mem_lat cycles after a request appears
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_auto) begin
            mem_ready = 1'b0;
            if (!rst && (mem_req_r || mem_req_w)) begin
               lat_cnt++;
               if (lat_cnt >= mem_lat) begin
                  lat_cnt   = 0;
                  mem_ready = 1'b1;
                  if (mem_req_r) begin
                     for (int k = 0; k < WPL; k++)
                        mem_rdata[k*32 +: 32] = store_rd(mem_addr + 32'(4*k));
                  end else begin
                     store[mem_addr[31:2]] = mem_wdata;
                     wr_count++;
                  end
               end
            end else begin
               lat_cnt = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && mem_r_en && ready) begin
         chk("sb_pending", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) chk("rdata", rdata, exp_q.pop_front());
      end
   end

   task automatic cpu_read(input logic [31:0] a, input bit exp_hit);
      int cyc = 0;
      bit saw = 1'b0;
      exp_q.push_back(store_rd(a));
      mem_r_en = 1'b1;
      addr     = a;
      forever begin
         @(negedge clk);
         if (mem_req_r && !saw) begin
            saw = 1'b1;
            chk("fill_addr", mem_addr, a & ~32'(4*WPL-1));
         end
         if (ready) break;
         cyc++;
         if (cyc > 100) begin
            chk("rd_timeout", 32'(cyc), 32'd0);
            break;
         end
      end
      chk("rd_hit", {31'b0, !saw}, {31'b0, exp_hit});
      chk("rd_latency", 32'(cyc), exp_hit ? 32'd0 : 32'(mem_lat));
      @(posedge clk); #1;
      mem_r_en = 1'b0;
   endtask

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
      int cyc = 0;
      bit saw = 1'b0;
      int wc0 = wr_count;
      mem_w_en = 1'b1;
      addr     = a;
      wdata    = d;
      forever begin
         @(negedge clk);
         if (mem_req_w && !saw) begin
            saw = 1'b1;
            chk("wt_addr", mem_addr, a);
            chk("wt_data", mem_wdata, d);
         end
         if (ready) break;
         cyc++;
         if (cyc > 100) begin
            chk("wr_timeout", 32'(cyc), 32'd0);
            break;
         end
      end
      @(posedge clk); #1;
      mem_w_en = 1'b0;
      chk("wt_count", 32'(wr_count - wc0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0;
      store[32'h40 >> 2] = 32'h1111_1111;
      store[32'h44 >> 2] = 32'h2222_2222;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'b0, ready}, 32'd1);
      chk("rst_req_r", {31'b0, mem_req_r}, 32'd0);
      chk("rst_req_w", {31'b0, mem_req_w}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(posedge clk); #1;

      cpu_read(32'h0000_0040, 1'b0);
      cpu_read(32'h0000_0044, 1'b1);
      cpu_read(32'h0000_2040, 1'b0);
      cpu_read(32'h0000_4040, 1'b0);
      cpu_read(32'h0000_2044, 1'b1);
      cpu_read(32'h0000_0040, 1'b0);

      cpu_write(32'h0000_0040, 32'hDEAD_BEEF);
      cpu_read(32'h0000_0040, wr_upd);
      cpu_read(32'h0000_0044, 1'b1);

      cpu_write(32'h0000_8000, 32'h1234_5678);
      cpu_read(32'h0000_8000, 1'b0);
      cpu_read(32'h0000_8004, 1'b1);

      mem_lat = 1;
      cpu_read(32'h0000_0104, 1'b0);
      cpu_read(32'h0000_0100, 1'b1);
      mem_lat = 3;

      // reset two cycles into a fill, then a stale mem_ready
      mem_auto = 1'b0;
      mem_r_en = 1'b1;
      addr     = 32'h0000_6000;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_rst_req_r", {31'b0, mem_req_r}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      mem_r_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = {32'hBAD0_0002, 32'hBAD0_0001};
      @(negedge clk);
      chk("ar_req_r", {31'b0, mem_req_r}, 32'd0);
      chk("ar_ready", {31'b0, ready}, 32'd1);
      chk("ar_rdata", rdata, 32'd0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_auto  = 1'b1;
      cpu_read(32'h0000_6000, 1'b0);
      cpu_read(32'h0000_0044, 1'b0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
